// File: rtl/mips_defs_pkg.sv
// Shared constants and types for the pipeline control logic.
// Stall masks, exception codes and the control FSM state encoding.
package mips_defs_pkg;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [31:0] EXC_NONE        = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET        = 32'h0000_000e;
   localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles; raises a sticky flag on timeout.
// The counter saturates so the flag stays meaningful under long holds.
module stall_watchdog #(
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] stall,
   input  logic       flush,
   output logic       stall_timeout
);

   localparam int CW = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = '0;
      if (!flush && (stall != 6'b0)) begin
         cnt_nxt = (cnt == LIMIT) ? LIMIT : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= '0;
         stall_timeout <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (cnt_nxt == LIMIT) begin
            stall_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception flush/redirect, fetch drain.
// All outputs are forced low while reset is asserted.
module pipe_ctrl
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DFLT,
   parameter int          STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        pc_reload,
   output logic        stall_timeout
);

   pipe_ctrl_state_t state;
   pipe_ctrl_state_t state_nxt;
   logic [31:0]      pending_pc;
   logic [31:0]      pending_nxt;
   logic [5:0]       mask;
   logic             exc_valid;
   logic [31:0]      target;

   always_comb begin
      mask = STALL_NONE;
      priority case (1'b1)
         stallreq_mem: mask = STALL_MEM;
         stallreq_ex:  mask = STALL_EX;
         stallreq_id:  mask = STALL_ID;
         stallreq_if:  mask = STALL_IF;
         default:      mask = STALL_NONE;
      endcase
   end

   assign exc_valid = (excepttype_i != EXC_NONE) && !stallreq_mem;
   assign target    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending_pc;
      stall       = STALL_NONE;
      flush       = 1'b0;
      new_pc      = 32'h0;
      pc_reload   = 1'b0;
      if (rst) begin
         unique case (state)
            RUN: begin
               if (exc_valid) begin
                  flush       = 1'b1;
                  new_pc      = target;
                  pending_nxt = target;
                  state_nxt   = stallreq_if ? DRAIN : RUN;
               end else begin
                  stall = mask;
               end
            end
            DRAIN: begin
               // Stale fetch still in flight; reload PC once it lands.
               stall  = STALL_IF;
               new_pc = pending_pc;
               if (!stallreq_if) begin
                  pc_reload = 1'b1;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         pending_pc <= 32'h0;
      end else begin
         state      <= state_nxt;
         pending_pc <= pending_nxt;
      end
   end

   stall_watchdog #(
      .STALL_TIMEOUT(STALL_TIMEOUT)
   ) u_watchdog (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .stall_timeout(stall_timeout)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Watchdog limit is shortened to 4 cycles.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallreq_if = 1'b0;
   logic        stallreq_id = 1'b0;
   logic        stallreq_ex = 1'b0;
   logic        stallreq_mem = 1'b0;
   logic [31:0] excepttype_i = 32'h0;
   logic [31:0] cp0_epc_i = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        pc_reload;
   logic        stall_timeout;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(
      .EXC_VECTOR   (32'hBFC00380),
      .STALL_TIMEOUT(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excepttype_i (excepttype_i),
      .cp0_epc_i    (cp0_epc_i),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .pc_reload    (pc_reload),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      stallreq_if  = 1'b0;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      stallreq_mem = 1'b0;
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      stallreq_mem = 1'b1;
      stallreq_if  = 1'b1;
      excepttype_i = 32'h1;
      #3;
      checks++;
      if (stall !== 6'b0) begin
         errors++;
         $display("FAIL rst_stall: got %b want %b", stall, 6'b0);
      end
      checks++;
      if ({flush, pc_reload, stall_timeout} !== 3'b000) begin
         errors++;
         $display("FAIL rst_flags: got %b want 000",
                  {flush, pc_reload, stall_timeout});
      end
      checks++;
      if (new_pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_new_pc: got %h want 0", new_pc);
      end
      clear_in();
      #1 rst = 1'b1;
      tick();
   endtask

   task automatic test_id_stall();
      stallreq_id = 1'b1;
      #1;
      checks++;
      if (stall !== 6'b000111) begin
         errors++;
         $display("FAIL id_stall: got %b want %b", stall, 6'b000111);
      end
      checks++;
      if ((stall[2] & ~stall[3]) !== 1'b1) begin
         errors++;
         $display("FAIL id_bubble: got %b want 1", stall[2] & ~stall[3]);
      end
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL id_flush: got %b want 0", flush);
      end
      clear_in();
      tick();
   endtask

   task automatic test_priority();
      stallreq_if  = 1'b1;
      stallreq_mem = 1'b1;
      #1;
      checks++;
      if (stall !== 6'b011111) begin
         errors++;
         $display("FAIL prio_mem: got %b want %b", stall, 6'b011111);
      end
      tick();
      stallreq_mem = 1'b0;
      #1;
      checks++;
      if (stall !== 6'b000011) begin
         errors++;
         $display("FAIL prio_if: got %b want %b", stall, 6'b000011);
      end
      stallreq_if = 1'b0;
      stallreq_ex = 1'b1;
      stallreq_id = 1'b1;
      #1;
      checks++;
      if (stall !== 6'b001111) begin
         errors++;
         $display("FAIL prio_ex: got %b want %b", stall, 6'b001111);
      end
      clear_in();
      tick();
   endtask

   task automatic test_syscall();
      excepttype_i = 32'h1;
      stallreq_id  = 1'b1;
      #1;
      checks++;
      if ({flush, stall} !== {1'b1, 6'b0}) begin
         errors++;
         $display("FAIL sys_flush: got %b/%b want 1/000000", flush, stall);
      end
      checks++;
      if (new_pc !== 32'hBFC00380) begin
         errors++;
         $display("FAIL sys_new_pc: got %h want bfc00380", new_pc);
      end
      tick();
      clear_in();
      #1;
      checks++;
      if ({flush, pc_reload, stall, new_pc} !== 40'h0) begin
         errors++;
         $display("FAIL sys_run: got %b %b %b %h want all 0",
                  flush, pc_reload, stall, new_pc);
      end
      tick();
   endtask

   task automatic test_eret_drain();
      excepttype_i = 32'he;
      cp0_epc_i    = 32'h80001234;
      stallreq_if  = 1'b1;
      #1;
      checks++;
      if ({flush, stall, new_pc} !== {1'b1, 6'b0, 32'h80001234}) begin
         errors++;
         $display("FAIL eret_flush: got %b %b %h want 1 000000 80001234",
                  flush, stall, new_pc);
      end
      tick();
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h0;
      stallreq_mem = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({flush, pc_reload, stall, new_pc} !==
             {1'b0, 1'b0, 6'b000011, 32'h80001234}) begin
            errors++;
            $display("FAIL drain_%0d: got %b %b %b %h want 0 0 000011 80001234",
                     i, flush, pc_reload, stall, new_pc);
         end
         tick();
      end
      stallreq_if  = 1'b0;
      stallreq_mem = 1'b0;
      #1;
      checks++;
      if ({flush, pc_reload, stall, new_pc} !==
          {1'b0, 1'b1, 6'b000011, 32'h80001234}) begin
         errors++;
         $display("FAIL drain_reload: got %b %b %b %h want 0 1 000011 80001234",
                  flush, pc_reload, stall, new_pc);
      end
      tick();
      #1;
      checks++;
      if ({pc_reload, stall, new_pc} !== 39'h0) begin
         errors++;
         $display("FAIL drain_exit: got %b %b %h want 0 000000 0",
                  pc_reload, stall, new_pc);
      end
      clear_in();
      tick();
   endtask

   task automatic test_mem_blocks_exc();
      excepttype_i = 32'h1;
      stallreq_mem = 1'b1;
      #1;
      checks++;
      if ({flush, stall, new_pc} !== {1'b0, 6'b011111, 32'h0}) begin
         errors++;
         $display("FAIL memexc_hold: got %b %b %h want 0 011111 0",
                  flush, stall, new_pc);
      end
      tick();
      stallreq_mem = 1'b0;
      #1;
      checks++;
      if ({flush, stall, new_pc} !== {1'b1, 6'b0, 32'hBFC00380}) begin
         errors++;
         $display("FAIL memexc_flush: got %b %b %h want 1 000000 bfc00380",
                  flush, stall, new_pc);
      end
      tick();
      clear_in();
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wd_init: got %b want 0", stall_timeout);
      end
      stallreq_ex = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wd_early: got %b want 0", stall_timeout);
      end
      tick();
      checks++;
      if (stall_timeout !== 1'b1) begin
         errors++;
         $display("FAIL wd_set: got %b want 1", stall_timeout);
      end
      clear_in();
      tick();
      tick();
      checks++;
      if ({stall_timeout, stall} !== {1'b1, 6'b0}) begin
         errors++;
         $display("FAIL wd_sticky: got %b %b want 1 000000",
                  stall_timeout, stall);
      end
   endtask

   task automatic test_reset_in_drain();
      excepttype_i = 32'h1;
      stallreq_if  = 1'b1;
      tick();
      excepttype_i = 32'h0;
      stallreq_mem = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall, flush, new_pc, pc_reload, stall_timeout} !== 41'h0) begin
         errors++;
         $display("FAIL rstdrain_out: got %b %b %h %b %b want all 0",
                  stall, flush, new_pc, pc_reload, stall_timeout);
      end
      clear_in();
      rst = 1'b1;
      #1;
      checks++;
      if ({stall, pc_reload, new_pc} !== 39'h0) begin
         errors++;
         $display("FAIL rstdrain_run: got %b %b %h want 000000 0 0",
                  stall, pc_reload, new_pc);
      end
      tick();
      checks++;
      if ({stall, pc_reload, new_pc} !== 39'h0) begin
         errors++;
         $display("FAIL rstdrain_after: got %b %b %h want 000000 0 0",
                  stall, pc_reload, new_pc);
      end
   endtask

   initial begin
      test_reset();
      test_id_stall();
      test_priority();
      test_syscall();
      test_eret_drain();
      test_mem_blocks_exc();
      test_watchdog();
      test_reset_in_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
